// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding, requester ids, byte-enable codes and alignment checks for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic ID_FETCH = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic fetch_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

    // Illegal codes and codes whose lane disagrees with the byte offset are both errors.
    function automatic logic data_misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: bad = (be != (4'b0001 << addr_lo));
            BE_H0:                      bad = (addr_lo != 2'b00);
            BE_H1:                      bad = (addr_lo != 2'b10);
            BE_W:                       bad = (addr_lo != 2'b00);
            default:                    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - counts data grants taken while a fetch waits and forces a fetch win at the limit
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic i_gnt_i,
    input  logic d_gnt_i,
    output logic fetch_win_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_gnt_i) begin
            cnt_d = 3'd0;
        end else if (d_gnt_i && i_req_i && (cnt_q != 3'd7)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_win_o = i_req_i && d_req_i && (cnt_q == 3'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for a shared fixed-latency RAM; MEM_ARB_STARVE_EN enables the fetch starvation guard
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-3:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    arb_state_e    state_q, state_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [3:0]    be_q, be_d;
    logic [AW-3:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic idle, issue, resp, fetch_win, starve_win;

    assign idle      = (state_q == ST_IDLE) && !rst;
    assign issue     = (state_q == ST_ISSUE) && !rst;
    assign resp      = (state_q == ST_RESP) && !rst;
    assign fetch_win = i_req && (!d_req || starve_win);
    assign i_gnt     = idle && fetch_win;
    assign d_gnt     = idle && d_req && !fetch_win;

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_req_i     (i_req),
        .d_req_i     (d_req),
        .i_gnt_i     (i_gnt),
        .d_gnt_i     (d_gnt),
        .fetch_win_o (starve_win)
    );
`else
    logic [31:0] unused_starve_max;
    assign starve_win        = 1'b0;
    assign unused_starve_max = 32'(STARVE_MAX);
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        err_d     = err_q;
        be_d      = be_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_gnt) begin
                    id_d    = ID_FETCH;
                    we_d    = 1'b0;
                    be_d    = BE_W;
                    waddr_d = i_addr[AW-1:2];
                    wdata_d = 32'h0;
                    err_d   = fetch_misaligned(i_addr[1:0]);
                    state_d = err_d ? ST_RESP : ST_ISSUE;
                end else if (d_gnt) begin
                    id_d    = ID_DATA;
                    we_d    = d_we;
                    be_d    = d_be;
                    waddr_d = d_addr[AW-1:2];
                    wdata_d = d_wdata;
                    err_d   = data_misaligned(d_be, d_addr[1:0]);
                    state_d = err_d ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // m_rdata is valid in the cycle the count reaches zero.
                if (cnt_q == 2'd0) begin
                    if (!we_q) begin
                        if (id_q == ID_FETCH) begin
                            i_rdata_d = m_rdata;
                        end else begin
                            d_rdata_d = m_rdata;
                        end
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            id_q      <= ID_FETCH;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            be_q      <= 4'h0;
            waddr_q   <= '0;
            wdata_q   <= 32'h0;
            cnt_q     <= 2'd0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            err_q     <= err_d;
            be_q      <= be_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_en    = issue;
    assign m_we    = issue && we_q;
    assign m_be    = issue ? be_q : 4'h0;
    assign m_addr  = issue ? waddr_q : '0;
    assign m_wdata = (issue && we_q) ? wdata_q : 32'h0;

    assign i_rvalid = resp && (id_q == ID_FETCH) && !err_q;
    assign i_err    = resp && (id_q == ID_FETCH) && err_q;
    assign d_rvalid = resp && (id_q == ID_DATA) && !err_q;
    assign d_err    = resp && (id_q == ID_DATA) && err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

    localparam int AW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_err;
    logic [31:0]   i_rdata;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic          m_en, m_we;
    logic [3:0]    m_be;
    logic [AW-3:0] m_addr;
    logic [31:0]   m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Environment RAM: 64 words, fixed read latency.
    logic [31:0] mem_seed;
    logic        init_req;
    logic [31:0] env_mem [64];
    logic [31:0] rd_pipe [4];

    function automatic logic [31:0] init_val(input int w);
        return (w == 4) ? 32'h0050_0093 : (mem_seed ^ (32'(w) * 32'h9E37_79B9));
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int w = 0; w < 64; w++) env_mem[w] <= init_val(w);
        end else if (m_en && m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) env_mem[m_addr[5:0]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (m_en && !m_we) ? env_mem[m_addr[5:0]] : 32'hDEAD_BEEF;
        for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign m_rdata = rd_pipe[MEM_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one access in flight, timing derived from the grant cycle.
    logic [31:0]  mmem [64];
    int           en_at = -1, resp_at = -1, next_free = 0, streak = 0;
    logic [67:0]  en_exp;
    logic [3:0]   resp_exp;
    logic [31:0]  rd_pend;
    logic         resp_load;
    logic [31:0]  exp_irdata = 32'h0, exp_drdata = 32'h0;
    bit           drdata_known = 1'b1;

    function automatic bit be_legal(input logic [3:0] be, input logic [1:0] lo);
        int n;
        n = $countones(be);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if ((int'(lo) % n) != 0) return 1'b0;
        return be == 4'(((1 << n) - 1) << lo);
    endfunction

    task automatic model_step();
        logic [1:0]  eg;
        logic [3:0]  er;
        logic [67:0] em;
        logic        fetch_first, bad;
        eg = '0; er = '0; em = '0;
        if (rst) begin
            en_at = -1; resp_at = -1; next_free = cyc + 1; streak = 0;
            chk("gnt", {i_gnt, d_gnt}, eg);
            chk("resp", {i_rvalid, i_err, d_rvalid, d_err}, er);
            chk("mem_port", {m_en, m_we, m_be, m_addr, m_wdata}, em);
            exp_irdata = 32'h0; exp_drdata = 32'h0; drdata_known = 1'b1;
            return;
        end
        if (cyc == en_at) em = en_exp;
        if (cyc == resp_at) begin
            er = resp_exp;
            if (er[3]) exp_irdata = rd_pend;
            if (er[1]) begin
                drdata_known = resp_load;
                if (resp_load) exp_drdata = rd_pend;
            end
        end
        if (cyc >= next_free && (i_req || d_req)) begin
`ifdef MEM_ARB_STARVE_EN
            fetch_first = i_req && (!d_req || streak == STARVE_MAX);
`else
            fetch_first = i_req && !d_req;
`endif
            if (fetch_first) begin
                eg = 2'b10; streak = 0;
                bad = (i_addr % 4) != 0;
                en_exp = {1'b1, 1'b0, 4'hF, i_addr[31:2], 32'h0};
                rd_pend = mmem[i_addr[7:2]];
                resp_exp = bad ? 4'b0100 : 4'b1000;
                resp_load = 1'b0;
            end else begin
                eg = 2'b01;
                if (i_req) streak++;
                bad = !be_legal(d_be, d_addr[1:0]);
                en_exp = {1'b1, d_we, d_be, d_addr[31:2], d_we ? d_wdata : 32'h0};
                resp_exp = bad ? 4'b0001 : 4'b0010;
                resp_load = !d_we;
                if (!bad && d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) mmem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                end else if (!bad) begin
                    rd_pend = mmem[d_addr[7:2]];
                end
            end
            if (bad) begin
                en_at = -1; resp_at = cyc + 1; next_free = cyc + 2;
            end else begin
                en_at = cyc + 1; resp_at = cyc + 2 + MEM_LAT; next_free = cyc + 3 + MEM_LAT;
            end
        end
        chk("gnt", {i_gnt, d_gnt}, eg);
        chk("resp", {i_rvalid, i_err, d_rvalid, d_err}, er);
        chk("mem_port", {m_en, m_we, m_be, m_addr, m_wdata}, em);
        chk("i_rdata", i_rdata, exp_irdata);
        if (drdata_known) chk("d_rdata", d_rdata, exp_drdata);
    endtask

    // Event log of what the DUT did, for the directed checks.
    int   i_gnt_c, d_gnt_c, i_rv_c, d_rv_c, i_err_c, d_err_c, men_cnt, d_rv_cnt;
    logic [31:0] i_rv_data;
    bit   gq [$];
    bit   g_i, g_d, d_keep = 1'b0, rnd_on = 1'b0;

    task automatic clear_log();
        i_gnt_c = -1; d_gnt_c = -1; i_rv_c = -1; d_rv_c = -1; i_err_c = -1; d_err_c = -1;
        men_cnt = 0; d_rv_cnt = 0; i_rv_data = 32'h0; gq.delete();
    endtask

    task automatic new_load();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'($urandom_range(63)) << 2; d_wdata = $urandom;
    endtask

    task automatic rand_fetch();
        logic [31:0] a;
        a = 32'($urandom_range(63)) << 2;
        if ($urandom_range(7) == 0) a = a + 32'($urandom_range(3));
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic rand_data();
        int sel, lane;
        logic [31:0] w;
        sel = $urandom_range(9);
        w = 32'($urandom_range(63)) << 2;
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_wdata = $urandom;
        lane = $urandom_range(3);
        if (sel < 3) begin
            d_be = 4'b0001 << lane; d_addr = w + 32'(lane);
        end else if (sel < 5) begin
            d_be = lane[0] ? 4'b1100 : 4'b0011; d_addr = w + (lane[0] ? 32'd2 : 32'd0);
        end else if (sel < 8) begin
            d_be = 4'hF; d_addr = w;
        end else begin
            d_be = 4'($urandom_range(15)); d_addr = 32'($urandom_range(255));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        g_i = i_gnt; g_d = d_gnt;
        if (i_gnt) begin i_gnt_c = cyc; gq.push_back(1'b0); end
        if (d_gnt) begin d_gnt_c = cyc; gq.push_back(1'b1); end
        if (i_rvalid) begin i_rv_c = cyc; i_rv_data = i_rdata; end
        if (d_rvalid) begin d_rv_c = cyc; d_rv_cnt++; end
        if (i_err) i_err_c = cyc;
        if (d_err) d_err_c = cyc;
        if (m_en) men_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (g_i) i_req = 1'b0;
        if (g_d) begin
            d_req = 1'b0;
            if (d_keep) new_load();
        end
        if (rnd_on) begin
            if (!i_req && $urandom_range(3) == 0) rand_fetch();
            else if (i_req && $urandom_range(19) == 0) i_req = 1'b0;
            if (!d_req && $urandom_range(3) == 0) rand_data();
            else if (d_req && $urandom_range(19) == 0) d_req = 1'b0;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_i"}, {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err}, '0);
        chk({tag, "_m"}, {m_en, m_we, m_be, m_addr, m_wdata}, '0);
    endtask

    logic [31:0] old_w;
    logic [5:0]  pat;

    initial begin
        rst = 1'b1; init_req = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = 32'h0;
        mem_seed = $urandom;
        for (int w = 0; w < 64; w++) mmem[w] = init_val(w);
        clear_log();
        tick();
        init_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk_idle_outputs("reset_state");

        // Aligned fetch of word 4.
        clear_log();
        i_req = 1'b1; i_addr = 32'h10;
        repeat (8) tick();
        chk("fetch_latency", 128'(i_rv_c - i_gnt_c), 2 + MEM_LAT);
        chk("fetch_data", i_rv_data, 32'h0050_0093);
        chk("fetch_men", men_cnt, 1);

        // Byte store into lane 3 of word 8.
        clear_log();
        old_w = env_mem[8];
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1000; d_addr = 32'h23; d_wdata = 32'hAB00_0000;
        repeat (8) tick();
        chk("store_mem", env_mem[8], {8'hAB, old_w[23:0]});
        chk("store_done", 128'(d_rv_c - d_gnt_c), 2 + MEM_LAT);

        // Simultaneous requests: data first, fetch at the next idle cycle.
        clear_log();
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h30;
        repeat (14) tick();
        chk("sim_gnt_gap", 128'(i_gnt_c - d_gnt_c), 3 + MEM_LAT);
        chk("sim_rsp_order", (d_rv_c >= 0) && (d_rv_c < i_rv_c), 1'b1);

        // Misaligned data and fetch.
        clear_log();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h22;
        repeat (4) tick();
        chk("d_mis_err", 128'(d_err_c - d_gnt_c), 1);
        chk("d_mis_men", men_cnt, 0);
        clear_log();
        i_req = 1'b1; i_addr = 32'h2;
        repeat (4) tick();
        chk("i_mis_err", 128'(i_err_c - i_gnt_c), 1);
        chk("i_mis_men", men_cnt, 0);

        // Reset while a load is in WAIT.
        clear_log();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("reset_wait");
        i_req = 1'b1; i_addr = 32'h10;
        repeat (8) tick();
        chk("reset_no_rvalid", d_rv_cnt, 0);
        chk("reset_fetch_data", i_rv_data, 32'h0050_0093);

        // Data held continuously while a fetch waits.
        clear_log();
        d_keep = 1'b1;
        new_load();
        i_req = 1'b1; i_addr = 32'h18;
        repeat (40) tick();
        d_keep = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 6; k++) pat[5-k] = (k < gq.size()) ? gq[k] : 1'b0;
`ifdef MEM_ARB_STARVE_EN
        chk("starve_order", pat, 6'b111101);
`else
        chk("strict_order", pat, 6'b111111);
`endif
        chk("fetch_served", i_gnt_c >= 0, 1'b1);

        // Random traffic.
        rnd_on = 1'b1;
        repeat (3000) tick();
        rnd_on = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
